// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for an 8-bit LFSR word stream.
// Error counter and clear are built only when LFSR_CHECKER_ERRCNT_EN is defined.
module lfsr_checker #(
  parameter logic [7:0] TAPS       = 8'hB8,
  parameter int         LOCK_COUNT = 4,
  parameter int         MISS_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] lfsr_bits,
  input  logic       clear,
  output logic       locked,
  output logic       error,
  output logic [7:0] error_count,
  output logic       error_sat
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t     state_q, state_d;
  logic [7:0] pred_q, pred_d;
  logic [3:0] run_q, run_d, run_inc;
  logic       err_q, err_d;
  function automatic logic [7:0] nxt(input logic [7:0] x);
    return {x[6:0], ^(x & TAPS)};
  endfunction
  assign run_inc = run_q + 4'd1;
  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    run_d   = run_q;
    err_d   = 1'b0;
    if (valid) begin
      case (state_q)
        HUNT: if (lfsr_bits != 8'd0) begin
          pred_d  = nxt(lfsr_bits);
          run_d   = 4'd0;
          state_d = VERIFY;
        end
        VERIFY: if (lfsr_bits == pred_q) begin
          pred_d  = nxt(lfsr_bits);
          run_d   = (run_inc == 4'(LOCK_COUNT)) ? 4'd0 : run_inc;
          state_d = (run_inc == 4'(LOCK_COUNT)) ? LOCKED : VERIFY;
        end else begin
          state_d = HUNT;
        end
        default: begin
          // flywheel: prediction advances from itself, never from the input
          pred_d = nxt(pred_q);
          if (lfsr_bits == pred_q) begin
            run_d = 4'd0;
          end else begin
            err_d   = 1'b1;
            run_d   = run_inc;
            state_d = (run_inc == 4'(MISS_LIMIT)) ? HUNT : LOCKED;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      pred_q  <= 8'd0;
      run_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pred_q  <= pred_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end
  assign locked = (state_q == LOCKED);
  assign error  = err_q;
`ifdef LFSR_CHECKER_ERRCNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       sat_q;
  assign cnt_d = clear ? 8'd0 : (err_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= (cnt_d == 8'hFF);
    end
  end
  assign error_count = cnt_q;
  assign error_sat   = sat_q;
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign error_count  = 8'd0;
  assign error_sat    = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: scoreboard bench for lfsr_checker (counter expectations follow LFSR_CHECKER_ERRCNT_EN).
module tb_lfsr_checker;
`ifdef LFSR_CHECKER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int LOCK = 4;
  localparam int MISS = 3;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] lfsr_bits = 8'd0;
  logic       clear = 1'b0;
  logic       locked, error, error_sat;
  logic [7:0] error_count;
  int total = 0;
  int bad = 0;
  typedef struct packed {logic lk; logic er; logic [7:0] cnt; logic sat;} exp_t;
  exp_t sb[$];
  exp_t e;
  int         m_state;
  logic [7:0] m_pred, m_cnt, g;
  logic [3:0] m_run;
  logic       m_err;

  lfsr_checker dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .lfsr_bits(lfsr_bits), .clear(clear),
    .locked(locked), .error(error), .error_count(error_count), .error_sat(error_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] nx(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_pred = 8'd0; m_run = 4'd0; m_cnt = 8'd0; m_err = 1'b0;
    sb.delete();
  endtask

  task automatic model(input logic v, input logic [7:0] s, input logic c);
    logic [3:0] r1;
    m_err = 1'b0;
    r1 = m_run + 4'd1;
    if (v) begin
      if (m_state == 0) begin
        if (s != 8'd0) begin m_pred = nx(s); m_run = 4'd0; m_state = 1; end
      end else if (m_state == 1) begin
        if (s == m_pred) begin
          m_pred = nx(s); m_run = r1;
          if (int'(r1) == LOCK) begin m_state = 2; m_run = 4'd0; end
        end else m_state = 0;
      end else begin
        if (s != m_pred) begin
          m_err = 1'b1; m_run = r1;
          if (int'(r1) == MISS) m_state = 0;
        end else m_run = 4'd0;
        m_pred = nx(m_pred);
      end
    end
    if (c) m_cnt = 8'd0;
    else if (m_err && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    sb.push_back('{lk: m_state == 2, er: m_err, cnt: CNT_EN ? m_cnt : 8'd0,
                   sat: CNT_EN ? (m_cnt == 8'hFF) : 1'b0});
  endtask

  task automatic step(input logic v, input logic [7:0] s, input logic c);
    @(negedge clk);
    valid = v; lfsr_bits = s; clear = c;
    model(v, s, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    valid = 1'b0; clear = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({locked, error, error_count, error_sat} !== 11'd0) begin
      bad++; $display("FAIL reset_values got=%h exp=000", {locked, error, error_count, error_sat});
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    g = 8'h01;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, g, 1'b0);
      g = nx(g);
      e = sb.pop_front(); total++;
      if ({locked, error, error_count, error_sat} !== e) begin
        bad++; $display("FAIL clean_lock[%0d] got=%h exp=%h", i, {locked, error, error_count, error_sat}, e);
      end
      if (i == 3 || i == 4) begin
        total++;
        if (locked !== (i == 4)) begin
          bad++; $display("FAIL clean_lock_edge[%0d] locked=%b exp=%b", i, locked, i == 4);
        end
      end
    end
  endtask

  task automatic test_zero_lockup();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'h00, 1'b0);
      e = sb.pop_front(); total++;
      if ({locked, error, error_count, error_sat} !== e || locked !== 1'b0) begin
        bad++; $display("FAIL zero_lockup[%0d] got=%h exp=%h", i, {locked, error, error_count, error_sat}, e);
      end
    end
    g = 8'h5D;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, g, 1'b0);
      g = nx(g);
      e = sb.pop_front(); total++;
      if ({locked, error, error_count, error_sat} !== e) begin
        bad++; $display("FAIL zero_relock[%0d] got=%h exp=%h", i, {locked, error, error_count, error_sat}, e);
      end
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL zero_relock_final locked=%b exp=1", locked); end
  endtask

  task automatic test_single_error();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 2) ? 8'hFF : g, 1'b0);
      g = nx(g);
      e = sb.pop_front(); total++;
      if ({locked, error, error_count, error_sat} !== e) begin
        bad++; $display("FAIL single_error[%0d] got=%h exp=%h", i, {locked, error, error_count, error_sat}, e);
      end
      if (i == 2) begin
        total++;
        if ({locked, error, error_count} !== {1'b1, 1'b1, CNT_EN ? 8'd1 : 8'd0}) begin
          bad++; $display("FAIL single_error_pulse got=%h exp=%h", {locked, error, error_count},
                          {1'b1, 1'b1, CNT_EN ? 8'd1 : 8'd0});
        end
      end
    end
  endtask

  task automatic test_loss_of_lock();
    for (int i = 0; i < 11; i++) begin
      step(1'b1, (i < 3) ? ~g : g, 1'b0);
      g = nx(g);
      e = sb.pop_front(); total++;
      if ({locked, error, error_count, error_sat} !== e) begin
        bad++; $display("FAIL loss_of_lock[%0d] got=%h exp=%h", i, {locked, error, error_count, error_sat}, e);
      end
      if (i == 2) begin
        total++;
        if ({locked, error_count} !== {1'b0, CNT_EN ? 8'd4 : 8'd0}) begin
          bad++; $display("FAIL loss_of_lock_drop got=%h exp=%h", {locked, error_count}, {1'b0, CNT_EN ? 8'd4 : 8'd0});
        end
      end
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL loss_of_lock_relock locked=%b exp=1", locked); end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    for (int r = 0; r < 101; r++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b1, (i >= 5) ? (g ^ 8'h3C) : g, 1'b0);
        g = nx(g);
        e = sb.pop_front(); total++;
        if ({locked, error, error_count, error_sat} !== e) begin
          bad++; $display("FAIL saturation[%0d.%0d] got=%h exp=%h", r, i, {locked, error, error_count, error_sat}, e);
        end
      end
    end
    total++;
    if ({error_count, error_sat} !== (CNT_EN ? 9'h1FF : 9'h000)) begin
      bad++; $display("FAIL saturation_final got=%h exp=%h", {error_count, error_sat}, CNT_EN ? 9'h1FF : 9'h000);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (i == 5) ? ~g : g, i == 5);
      g = nx(g);
      e = sb.pop_front(); total++;
      if ({locked, error, error_count, error_sat} !== e) begin
        bad++; $display("FAIL clear[%0d] got=%h exp=%h", i, {locked, error, error_count, error_sat}, e);
      end
    end
    total++;
    if ({locked, error, error_count, error_sat} !== {1'b1, 1'b1, 8'd0, 1'b0}) begin
      bad++; $display("FAIL clear_with_mismatch got=%h exp=%h", {locked, error, error_count, error_sat},
                      {1'b1, 1'b1, 8'd0, 1'b0});
    end
  endtask

  task automatic test_gaps_async_reset();
    logic v;
    do_reset();
    g = 8'hA7;
    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 2) != 0);
      step(v, v ? ((i == 20) ? 8'h00 : g) : 8'($urandom), 1'b0);
      if (v) g = nx(g);
      e = sb.pop_front(); total++;
      if ({locked, error, error_count, error_sat} !== e) begin
        bad++; $display("FAIL gaps[%0d] got=%h exp=%h", i, {locked, error, error_count, error_sat}, e);
      end
    end
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL gaps_final locked=%b exp=1", locked); end
    step(1'b1, ~g, 1'b0);
    e = sb.pop_front();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({locked, error, error_count, error_sat} !== 11'd0) begin
      bad++; $display("FAIL async_reset got=%h exp=000", {locked, error, error_count, error_sat});
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 8'h01, 1'b0);
    e = sb.pop_front(); total++;
    if ({locked, error, error_count, error_sat} !== e) begin
      bad++; $display("FAIL post_reset got=%h exp=%h", {locked, error, error_count, error_sat}, e);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_zero_lockup();
    test_single_error();
    test_loss_of_lock();
    test_saturation_clear();
    test_gaps_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
